// File: rtl/udp_gen_pkg.sv
// Shared types and the payload pattern step function for the UDP traffic sequencer.
// Used by both the transmit pattern source and the optional receive checker.
package udp_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } gen_state_e;

    typedef enum logic {
        PAT_INC  = 1'b0,
        PAT_LFSR = 1'b1
    } pat_mode_e;

    // Feedback taps b7, b5, b4, b3 of x^8+x^6+x^5+x^4+1 in shift-left form.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] pat_next(input logic [7:0] cur,
                                            input pat_mode_e mode,
                                            input logic [7:0] inc);
        if (mode == PAT_LFSR) begin
            return {cur[6:0], ^(cur & LFSR_TAPS)};
        end
        return cur + inc;
    endfunction

endpackage

// File: rtl/udp_pat_gen.sv
// Payload byte source: reloads SEED on load, otherwise advances one pattern step per step pulse.
// Load has priority over step so an end-of-packet always restarts the sequence.
module udp_pat_gen
    import udp_gen_pkg::*;
#(
    parameter logic [7:0] SEED = 8'h33,
    parameter logic [7:0] INC  = 8'h11
) (
    input  logic       gmii_tx_clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    input  pat_mode_e  mode,
    output logic [7:0] pat_byte
);

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_byte <= SEED;
        end else if (load) begin
            pat_byte <= SEED;
        end else if (step) begin
            pat_byte <= pat_next(pat_byte, mode, INC);
        end
    end

endmodule

// File: rtl/udp_pkt_gen.sv
// UDP traffic sequencer: bursts of stepped-length packets with a tx_done watchdog.
// Define UDP_PKT_CHK_EN to add the receive-side pattern checker and its ports.
module udp_pkt_gen
    import udp_gen_pkg::*;
#(
    parameter int          PKT_NUM    = 2,
    parameter logic [15:0] LEN_MIN    = 16'd10,
    parameter logic [15:0] LEN_STEP   = 16'd20,
    parameter logic [15:0] LEN_MAX    = 16'd1472,
    parameter int          GAP_CYCLES = 100,
    parameter logic [7:0]  SEED       = 8'h33,
    parameter logic [7:0]  INC        = 8'h11,
    parameter int          TIMEOUT    = 65535,
    parameter logic [47:0] DES_MAC    = 48'hff_ff_ff_ff_ff_ff,
    parameter logic [31:0] DES_IP     = {8'd192, 8'd168, 8'd1, 8'd10}
) (
    input  logic        gmii_tx_clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        stop,
    input  logic        mode,
    input  logic        tx_req,
    input  logic        tx_done,
`ifdef UDP_PKT_CHK_EN
    input  logic        rec_en,
    input  logic [7:0]  rec_data,
    input  logic        rec_pkt_done,
    output logic [15:0] chk_pkt_cnt,
    output logic [15:0] chk_err_cnt,
`endif
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    output logic [7:0]  tx_data,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    output logic        busy,
    output logic [15:0] pkt_cnt,
    output logic        timeout_err
);

    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    gen_state_e       state_reg, state_next;
    logic [15:0]      len_reg, byte_num_reg, pkt_cnt_reg;
    logic [WD_W-1:0]  wd_cnt_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic             stop_seen_reg, timeout_err_reg;

    pat_mode_e        pat_mode;
    logic             run_start, pkt_end, wd_hit, gap_end, run_over;
    logic [16:0]      len_sum;
    logic [15:0]      len_wrap;

    assign pat_mode  = pat_mode_e'(mode);
    assign run_start = (state_reg == ST_IDLE) && run;
    assign pkt_end   = (state_reg == ST_WAIT) && tx_done;
    assign wd_hit    = (state_reg == ST_WAIT) && !tx_done && (wd_cnt_reg == WD_W'(TIMEOUT - 1));
    assign gap_end   = (state_reg == ST_GAP) && (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1));
    assign run_over  = stop_seen_reg || ((PKT_NUM != 0) && (pkt_cnt_reg == 16'(PKT_NUM)));

    // 17-bit sum so a step past 0xffff still counts as exceeding LEN_MAX.
    assign len_sum  = {1'b0, len_reg} + {1'b0, LEN_STEP};
    assign len_wrap = (len_sum > {1'b0, LEN_MAX}) ? LEN_MIN : len_sum[15:0];

    always_comb begin
        state_next  = state_reg;
        tx_start_en = 1'b0;
        unique case (state_reg)
            ST_IDLE:  if (run) state_next = ST_START;
            ST_START: begin
                tx_start_en = 1'b1;
                state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done)     state_next = ST_GAP;
                else if (wd_hit) state_next = ST_DONE;
            end
            ST_GAP:   if (gap_end) state_next = run_over ? ST_DONE : ST_START;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            len_reg         <= LEN_MIN;
            byte_num_reg    <= '0;
            pkt_cnt_reg     <= '0;
            wd_cnt_reg      <= '0;
            gap_cnt_reg     <= '0;
            stop_seen_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (busy && stop) stop_seen_reg <= 1'b1;
            unique case (state_reg)
                ST_IDLE: if (run) begin
                    len_reg         <= LEN_MIN;
                    byte_num_reg    <= LEN_MIN;
                    pkt_cnt_reg     <= '0;
                    stop_seen_reg   <= 1'b0;
                    timeout_err_reg <= 1'b0;
                end
                ST_START: wd_cnt_reg <= '0;
                ST_WAIT: begin
                    wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
                    if (tx_done) begin
                        if (pkt_cnt_reg != 16'hffff) pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
                        len_reg     <= len_wrap;
                        gap_cnt_reg <= '0;
                    end else if (wd_hit) begin
                        timeout_err_reg <= 1'b1;
                    end
                end
                ST_GAP: begin
                    gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
                    if (gap_end && !run_over) byte_num_reg <= len_reg;
                end
                default: ;
            endcase
        end
    end

    // Reload on entry to START so tx_data already shows SEED during the start pulse.
    udp_pat_gen #(.SEED(SEED), .INC(INC)) u_tx_pat (
        .gmii_tx_clk (gmii_tx_clk),
        .rst_n       (rst_n),
        .load        ((state_next == ST_START) || pkt_end),
        .step        ((state_reg == ST_WAIT) && tx_req),
        .mode        (pat_mode),
        .pat_byte    (tx_data)
    );

    assign busy        = (state_reg != ST_IDLE);
    assign des_mac     = busy ? DES_MAC : '0;
    assign des_ip      = busy ? DES_IP : '0;
    assign tx_byte_num = byte_num_reg;
    assign pkt_cnt     = pkt_cnt_reg;
    assign timeout_err = timeout_err_reg;

`ifdef UDP_PKT_CHK_EN
    logic [7:0]  chk_byte;
    logic [15:0] chk_pkt_reg, chk_err_reg;

    udp_pat_gen #(.SEED(SEED), .INC(INC)) u_chk_pat (
        .gmii_tx_clk (gmii_tx_clk),
        .rst_n       (rst_n),
        .load        (run_start || rec_pkt_done),
        .step        (rec_en),
        .mode        (pat_mode),
        .pat_byte    (chk_byte)
    );

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_pkt_reg <= '0;
            chk_err_reg <= '0;
        end else if (run_start) begin
            chk_pkt_reg <= '0;
            chk_err_reg <= '0;
        end else begin
            if (rec_en && (rec_data != chk_byte) && (chk_err_reg != 16'hffff))
                chk_err_reg <= chk_err_reg + 16'd1;
            if (rec_pkt_done && (chk_pkt_reg != 16'hffff))
                chk_pkt_reg <= chk_pkt_reg + 16'd1;
        end
    end

    assign chk_pkt_cnt = chk_pkt_reg;
    assign chk_err_cnt = chk_err_reg;
`endif

endmodule

// File: tb/tb_udp_pkt_gen.sv
// Scoreboard bench for udp_pkt_gen: a run planner queues expected packets, a start monitor
// checks each tx_start_en against them, and a udp responder model checks every payload byte.
module tb_udp_pkt_gen;

    localparam int          PKT_NUM    = 3;
    localparam int          LEN_MIN    = 10;
    localparam int          LEN_STEP   = 20;
    localparam int          LEN_MAX    = 40;
    localparam int          GAP_CYCLES = 5;
    localparam logic [7:0]  SEED       = 8'h33;
    localparam logic [7:0]  INC        = 8'h11;
    localparam int          TIMEOUT    = 200;
    localparam logic [47:0] DES_MAC    = 48'h02_11_22_33_44_55;
    localparam logic [31:0] DES_IP     = {8'd192, 8'd168, 8'd1, 8'd10};

    logic        gmii_tx_clk = 1'b0;
    logic        rst_n = 1'b0, run = 1'b0, stop = 1'b0, mode = 1'b0;
    logic        tx_req = 1'b0, tx_done = 1'b0;
    logic        tx_start_en, busy, timeout_err;
    logic [15:0] tx_byte_num, pkt_cnt;
    logic [7:0]  tx_data;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
`ifdef UDP_PKT_CHK_EN
    logic        rec_en = 1'b0, rec_pkt_done = 1'b0;
    logic [7:0]  rec_data = 8'h00;
    logic [15:0] chk_pkt_cnt, chk_err_cnt;
`endif

    udp_pkt_gen #(
        .PKT_NUM(PKT_NUM), .LEN_MIN(16'(LEN_MIN)), .LEN_STEP(16'(LEN_STEP)),
        .LEN_MAX(16'(LEN_MAX)), .GAP_CYCLES(GAP_CYCLES), .SEED(SEED), .INC(INC),
        .TIMEOUT(TIMEOUT), .DES_MAC(DES_MAC), .DES_IP(DES_IP)
    ) dut (
        .gmii_tx_clk (gmii_tx_clk),
        .rst_n       (rst_n),
        .run         (run),
        .stop        (stop),
        .mode        (mode),
        .tx_req      (tx_req),
        .tx_done     (tx_done),
`ifdef UDP_PKT_CHK_EN
        .rec_en       (rec_en),
        .rec_data     (rec_data),
        .rec_pkt_done (rec_pkt_done),
        .chk_pkt_cnt  (chk_pkt_cnt),
        .chk_err_cnt  (chk_err_cnt),
`endif
        .tx_start_en (tx_start_en),
        .tx_byte_num (tx_byte_num),
        .tx_data     (tx_data),
        .des_mac     (des_mac),
        .des_ip      (des_ip),
        .busy        (busy),
        .pkt_cnt     (pkt_cnt),
        .timeout_err (timeout_err)
    );

    always #4 gmii_tx_clk = ~gmii_tx_clk;

    typedef struct {
        int len;
        bit m;
    } pkt_t;

    int         total = 0;
    int         bad = 0;
    int         start_cnt = 0;
    bit         withhold_done = 1'b0;
    pkt_t       exp_q[$];
    logic [7:0] exp_bytes[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference pattern from the spec's rules, computed with integer arithmetic.
    function automatic logic [7:0] model_next(input logic [7:0] b, input bit m);
        int bi, fb;
        bi = int'(b);
        if (!m) return 8'((bi + int'(INC)) % 256);
        fb = ((bi >> 7) ^ (bi >> 5) ^ (bi >> 4) ^ (bi >> 3)) & 1;
        return 8'(((bi * 2) % 256) + fb);
    endfunction

    task automatic plan_run(input int npkt, input bit m);
        int len;
        len = LEN_MIN;
        for (int i = 0; i < npkt; i++) begin
            exp_q.push_back('{len, m});
            len = len + LEN_STEP;
            if (len > LEN_MAX) len = LEN_MIN;
        end
    endtask

    task automatic set_rx(input logic en, input logic [7:0] data, input logic done);
`ifdef UDP_PKT_CHK_EN
        rec_en       = en;
        rec_data     = data;
        rec_pkt_done = done;
`else
        if (en && done && data == 8'h00) total = total + 0;
`endif
    endtask

    task automatic drop_inputs();
        tx_req  = 1'b0;
        tx_done = 1'b0;
        set_rx(1'b0, 8'h00, 1'b0);
    endtask

    // Start monitor: every tx_start_en must match the next planned packet.
    always @(negedge gmii_tx_clk) begin : start_monitor
        pkt_t       p;
        logic [7:0] b;
        if (rst_n && tx_start_en) begin
            start_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_start", 1, 0);
            end else begin
                p = exp_q.pop_front();
                check("tx_byte_num", tx_byte_num, 64'(p.len));
                check("start_seed", tx_data, SEED);
                exp_bytes.delete();
                b = SEED;
                for (int i = 0; i < p.len; i++) begin
                    exp_bytes.push_back(b);
                    b = model_next(b, p.m);
                end
                $display("start #%0d len=%0d mode=%0d", start_cnt, p.len, p.m);
            end
        end
    end

    // udp responder: fetches tx_byte_num bytes with random stalls, then pulses tx_done.
    task automatic serve_packet(input int len);
        logic [7:0] b;
        int         stall;
        for (int i = 0; i < len; i++) begin
            @(negedge gmii_tx_clk);
            if (!rst_n) begin drop_inputs(); return; end
            stall = $urandom_range(0, 2);
            if (stall != 0) begin
                tx_req = 1'b0;
                set_rx(1'b0, 8'h00, 1'b0);
                repeat (stall) begin
                    @(negedge gmii_tx_clk);
                    if (!rst_n) begin drop_inputs(); return; end
                end
            end
            b = tx_data;
            if (exp_bytes.size() == 0) check("extra_byte", 1, 0);
            else check("payload", b, exp_bytes.pop_front());
            tx_req = 1'b1;
            set_rx(1'b1, b, 1'b0);
        end
        @(negedge gmii_tx_clk);
        drop_inputs();
        if (!rst_n || withhold_done) return;
        repeat ($urandom_range(0, 2)) @(negedge gmii_tx_clk);
        if (!rst_n) return;
        tx_done = 1'b1;
        tx_req  = 1'($urandom_range(0, 1));
        set_rx(1'b0, 8'h00, 1'b1);
        @(negedge gmii_tx_clk);
        drop_inputs();
        if (rst_n) check("gap_seed", tx_data, SEED);
        $display("done len=%0d", len);
    endtask

    initial begin : udp_model
        forever begin
            @(negedge gmii_tx_clk);
            if (rst_n && tx_start_en) serve_packet(int'(tx_byte_num));
        end
    end

    task automatic pulse_run(input bit with_stop);
        @(negedge gmii_tx_clk);
        run  = 1'b1;
        stop = with_stop;
        @(negedge gmii_tx_clk);
        run  = 1'b0;
        stop = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge gmii_tx_clk);
            k++;
        end
        check(name, busy, 0);
    endtask

    task automatic wait_starts(input int n, input int budget);
        int k;
        k = 0;
        while (start_cnt < n && k < budget) begin
            @(negedge gmii_tx_clk);
            k++;
        end
        check("start_wait", 64'(start_cnt >= n), 1);
    endtask

    task automatic check_run_end(input int npkt, input bit tmo);
        check("pkt_cnt", pkt_cnt, 64'(npkt));
        check("timeout_err", timeout_err, 64'(tmo));
        check("des_mac_idle", des_mac, 0);
        check("pending_pkts", exp_q.size(), 0);
`ifdef UDP_PKT_CHK_EN
        check("chk_pkt_cnt", chk_pkt_cnt, 64'(npkt));
        check("chk_err_cnt", chk_err_cnt, 0);
`endif
        $display("run end pkt_cnt=%0d timeout_err=%0b", pkt_cnt, timeout_err);
    endtask

    initial begin : timeout_guard
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        bit m;
        int s, n;
        repeat (3) @(negedge gmii_tx_clk);
        check("rst_tx_start_en", tx_start_en, 0);
        check("rst_tx_byte_num", tx_byte_num, 0);
        check("rst_tx_data", tx_data, SEED);
        check("rst_des_mac", des_mac, 0);
        check("rst_des_ip", des_ip, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        @(negedge gmii_tx_clk);

        // Increment mode, full run of PKT_NUM packets with length wrap on the third.
        plan_run(PKT_NUM, 1'b0);
        mode = 1'b0;
        pulse_run(1'b0);
        check("busy_after_run", busy, 1);
        check("des_mac_busy", des_mac, DES_MAC);
        check("des_ip_busy", des_ip, DES_IP);
        wait_idle("run_a_idle", 3000);
        check_run_end(PKT_NUM, 1'b0);
        repeat (20) @(negedge gmii_tx_clk);

        // Stop in IDLE is ignored; run+stop together starts a full run; run while busy ignored.
        @(negedge gmii_tx_clk); stop = 1'b1;
        @(negedge gmii_tx_clk); stop = 1'b0;
        plan_run(PKT_NUM, 1'b1);
        mode = 1'b1;
        s = start_cnt;
        pulse_run(1'b1);
        wait_starts(s + 2, 2000);
        @(negedge gmii_tx_clk); run = 1'b1;
        @(negedge gmii_tx_clk); run = 1'b0;
        wait_idle("run_b_idle", 3000);
        check_run_end(PKT_NUM, 1'b0);
        repeat (20) @(negedge gmii_tx_clk);

        // Stop during packet 2 lets it finish and ends the run.
        m = 1'($urandom_range(0, 1));
        mode = m;
        plan_run(2, m);
        s = start_cnt;
        pulse_run(1'b0);
        wait_starts(s + 2, 2000);
        repeat (3) @(negedge gmii_tx_clk);
        stop = 1'b1;
        @(negedge gmii_tx_clk); stop = 1'b0;
        wait_idle("run_c_idle", 3000);
        check_run_end(2, 1'b0);
        repeat (20) @(negedge gmii_tx_clk);

        // Watchdog: tx_done withheld.
        withhold_done = 1'b1;
        mode = 1'b0;
        plan_run(1, 1'b0);
        pulse_run(1'b0);
        n = 0;
        while (!timeout_err && n < 2 * TIMEOUT) begin
            @(negedge gmii_tx_clk);
            n++;
        end
        check("timeout_window", 64'(n >= TIMEOUT && n <= TIMEOUT + 2), 1);
        $display("timeout seen %0d cycles after start", n);
        wait_idle("run_d_idle", 50);
        check("pkt_cnt_timeout", pkt_cnt, 0);
        check("timeout_sticky", timeout_err, 1);
        withhold_done = 1'b0;
        repeat (10) @(negedge gmii_tx_clk);

        // Next run clears timeout_err and restarts lengths at LEN_MIN.
        m = 1'($urandom_range(0, 1));
        mode = m;
        plan_run(PKT_NUM, m);
        pulse_run(1'b0);
        check("timeout_cleared", timeout_err, 0);
        wait_idle("run_e_idle", 3000);
        check_run_end(PKT_NUM, 1'b0);
        repeat (20) @(negedge gmii_tx_clk);

        // Asynchronous reset during WAIT of packet 2.
        mode = 1'b0;
        plan_run(PKT_NUM, 1'b0);
        s = start_cnt;
        pulse_run(1'b0);
        wait_starts(s + 2, 2000);
        repeat (4) @(negedge gmii_tx_clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_tx_start_en", tx_start_en, 0);
        check("arst_tx_data", tx_data, SEED);
        check("arst_tx_byte_num", tx_byte_num, 0);
        check("arst_pkt_cnt", pkt_cnt, 0);
        check("arst_des_ip", des_ip, 0);
        exp_q.delete();
        repeat (3) @(negedge gmii_tx_clk);
        exp_bytes.delete();
        drop_inputs();
        rst_n = 1'b1;
        repeat (3) @(negedge gmii_tx_clk);

        m = 1'($urandom_range(0, 1));
        mode = m;
        plan_run(PKT_NUM, m);
        pulse_run(1'b0);
        wait_idle("run_g_idle", 3000);
        check_run_end(PKT_NUM, 1'b0);
        repeat (20) @(negedge gmii_tx_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
